// File: rtl/cl_arith_pkg.sv
// Shared widths and the carry-less multiply helper for the GF(2^m)/integer arithmetic unit.
// Combinational only: no latency or backpressure of its own.
package cl_arith_pkg;

  parameter int DATA_WIDTH = 32;
  localparam int GRADE_W = $clog2(DATA_WIDTH) + 1;

  function automatic logic [2*DATA_WIDTH-1:0] clmul(input logic [DATA_WIDTH-1:0] x,
                                                    input logic [DATA_WIDTH-1:0] y);
    logic [2*DATA_WIDTH-1:0] acc;
    acc = '0;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      if (y[i]) acc = acc ^ ({{DATA_WIDTH{1'b0}}, x} << i);
    end
    return acc;
  endfunction

endpackage

// File: rtl/cl_arith_unit_if.sv
// Operand/select bundle into the arithmetic unit and its registered result bus.
// No handshake: inputs sampled every cycle, results valid one cycle later.
interface cl_arith_unit_if
  import cl_arith_pkg::*;
#(
  parameter int W = DATA_WIDTH
);
  localparam int GW = $clog2(W) + 1;

  logic            sum_funct;
  logic            exp_funct;
  logic            red_funct;
  logic            carry_option;
  logic [GW-1:0]   polyn_grade;
  logic [W:0]      polyn_red_in;
  logic [2*W-1:0]  reduc_in;
  logic [W-1:0]    a;
  logic [W-1:0]    b;
  logic [W-1:0]    out;
  logic            sum_carry_out;
  logic [2*W-1:0]  mult_out;
  logic [W-1:0]    out_poly;

  modport master (
    output sum_funct, exp_funct, red_funct, carry_option,
    output polyn_grade, polyn_red_in, reduc_in, a, b,
    input  out, sum_carry_out, mult_out, out_poly
  );

  modport slave (
    input  sum_funct, exp_funct, red_funct, carry_option,
    input  polyn_grade, polyn_red_in, reduc_in, a, b,
    output out, sum_carry_out, mult_out, out_poly
  );
endinterface

// File: rtl/cl_poly_reduce.sv
// Reduces a 2W-bit carry-less polynomial modulo P of degree m; out-of-range m yields 0.
// Purely combinational; the caller registers the result.
module cl_poly_reduce #(
  parameter int W  = 32,
  parameter int GW = $clog2(W) + 1
) (
  input  logic [2*W-1:0] reduc_i,
  input  logic [W:0]     poly_i,
  input  logic [GW-1:0]  grade_i,
  output logic [W-1:0]   poly_o
);
  localparam logic [W:0] ONE_P = {{W{1'b0}}, 1'b1};

  logic [W:0]     p_mask;
  logic [W:0]     p_eff;
  logic [2*W-1:0] p_ext;
  logic [2*W-1:0] r;
  int             mi;

  // Bits of P above m are don't-care and P[m] is forced, so a sloppy P still reduces correctly.
  assign p_mask = (ONE_P << grade_i) - ONE_P;
  assign p_eff  = (poly_i & p_mask) | (ONE_P << grade_i);
  assign p_ext  = {{(W-1){1'b0}}, p_eff};
  assign mi     = int'(grade_i);

  always_comb begin
    r      = reduc_i;
    poly_o = '0;
    if (mi >= 2 && mi <= W) begin
      for (int i = 2*W-1; i >= 2; i--) begin
        if (i >= mi && r[i]) r = r ^ (p_ext << (i - mi));
      end
      poly_o = r[W-1:0] & p_mask[W-1:0];
    end
  end
endmodule

// File: rtl/cl_arith_unit.sv
// Multi-function integer / GF(2) arithmetic core: add, multiply, square, polynomial reduce.
// Fixed 1-cycle registered latency, no handshake; unselected results register as 0.
module cl_arith_unit
  import cl_arith_pkg::*;
#(
  parameter int DATA_WIDTH = cl_arith_pkg::DATA_WIDTH
) (
  input logic            clk,
  input logic            rst_n,
  cl_arith_unit_if.slave bus
);
  localparam int W  = DATA_WIDTH;
  localparam int GW = $clog2(W) + 1;

  logic [W-1:0]   op_b;
  logic [2*W-1:0] int_prod;
  logic [2*W-1:0] pp  [W];
  logic [2*W-1:0] acc [W];
  logic [W-1:0]   red_poly;

  logic [W-1:0]   out_d,   out_q;
  logic           carry_d, carry_q;
  logic [2*W-1:0] mult_d,  mult_q;
  logic [W-1:0]   poly_d,  poly_q;

  // Squaring reuses the multiplier with a on both operands.
  assign op_b     = bus.exp_funct ? bus.a : bus.b;
  assign int_prod = {{W{1'b0}}, bus.a} * {{W{1'b0}}, op_b};

  genvar gi;
  generate
    for (gi = 0; gi < W; gi++) begin : g_clmul
      assign pp[gi] = op_b[gi] ? ({{W{1'b0}}, bus.a} << gi) : '0;
      if (gi == 0) begin : g_first
        assign acc[gi] = pp[gi];
      end else begin : g_rest
        assign acc[gi] = acc[gi-1] ^ pp[gi];
      end
    end
  endgenerate

  cl_poly_reduce #(.W(W), .GW(GW)) u_reduce (
    .reduc_i (bus.reduc_in),
    .poly_i  (bus.polyn_red_in),
    .grade_i (bus.polyn_grade),
    .poly_o  (red_poly)
  );

  always_comb begin
    out_d   = '0;
    carry_d = 1'b0;
    mult_d  = '0;
    poly_d  = '0;
    if (bus.red_funct) begin
      poly_d = red_poly;
    end else if (bus.sum_funct) begin
      if (bus.carry_option) {carry_d, out_d} = {1'b0, bus.a} + {1'b0, bus.b};
      else                  out_d = bus.a ^ bus.b;
    end else begin
      mult_d = bus.carry_option ? int_prod : acc[W-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q   <= '0;
      carry_q <= 1'b0;
      mult_q  <= '0;
      poly_q  <= '0;
    end else begin
      out_q   <= out_d;
      carry_q <= carry_d;
      mult_q  <= mult_d;
      poly_q  <= poly_d;
    end
  end

  assign bus.out           = out_q;
  assign bus.sum_carry_out = carry_q;
  assign bus.mult_out      = mult_q;
  assign bus.out_poly      = poly_q;
endmodule

// File: tb/tb_cl_arith_unit.sv
// Directed and randomized checks of cl_arith_unit against a behavioural model of its arithmetic rules.
module tb_cl_arith_unit;
  localparam int W = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cl_arith_unit_if #(.W(W)) bus ();
  cl_arith_unit #(.DATA_WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic [31:0] out;
    logic        c;
    logic [63:0] mult;
    logic [31:0] poly;
  } res_t;

  logic [32:0] irr_tab [17];

  function automatic logic [63:0] m_clmul(input logic [31:0] x, input logic [31:0] y);
    logic [63:0] r;
    r = 0;
    for (int i = 0; i < 32; i++) if (y[i]) r = r ^ (64'(x) << i);
    return r;
  endfunction

  function automatic logic [63:0] m_clsquare(input logic [31:0] x);
    logic [63:0] r;
    r = 0;
    for (int i = 0; i < 32; i++) r[2*i] = x[i];
    return r;
  endfunction

  function automatic logic [31:0] m_reduce(input logic [63:0] v, input logic [32:0] p, input int m);
    logic [63:0] pe;
    logic [63:0] rem;
    if (m < 2 || m > 32) return 0;
    pe  = 0;
    rem = v;
    for (int j = 0; j < m; j++) pe[j] = p[j];
    pe[m] = 1'b1;
    for (int i = 63; i >= m; i--) if (rem[i]) rem = rem ^ (pe << (i - m));
    return rem[31:0];
  endfunction

  function automatic res_t model();
    res_t r;
    r.out = 0; r.c = 0; r.mult = 0; r.poly = 0;
    if (bus.red_funct) begin
      r.poly = m_reduce(bus.reduc_in, bus.polyn_red_in, int'(bus.polyn_grade));
    end else if (bus.sum_funct) begin
      if (bus.carry_option) {r.c, r.out} = 33'(bus.a) + 33'(bus.b);
      else r.out = bus.a ^ bus.b;
    end else if (bus.exp_funct) begin
      r.mult = bus.carry_option ? 64'(bus.a) * 64'(bus.a) : m_clsquare(bus.a);
    end else begin
      r.mult = bus.carry_option ? 64'(bus.a) * 64'(bus.b) : m_clmul(bus.a, bus.b);
    end
    return r;
  endfunction

  task automatic check(input string tag, input logic [159:0] got, input logic [159:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic check_model(input string tag);
    res_t e;
    e = model();
    check({tag, ".out"},   160'(bus.out),           160'(e.out));
    check({tag, ".carry"}, 160'(bus.sum_carry_out), 160'(e.c));
    check({tag, ".mult"},  160'(bus.mult_out),      160'(e.mult));
    check({tag, ".poly"},  160'(bus.out_poly),      160'(e.poly));
  endtask

  task automatic drive(input logic s, input logic e, input logic r, input logic c,
                       input logic [5:0] m, input logic [32:0] p, input logic [63:0] v,
                       input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    bus.sum_funct = s; bus.exp_funct = e; bus.red_funct = r; bus.carry_option = c;
    bus.polyn_grade = m; bus.polyn_red_in = p; bus.reduc_in = v; bus.a = a; bus.b = b;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [128:0] all_out();
    return {bus.out, bus.sum_carry_out, bus.mult_out, bus.out_poly};
  endfunction

  initial begin
    logic [63:0] v;
    int m;
    logic [32:0] p;
    irr_tab[0] = 0; irr_tab[1] = 0;
    irr_tab[2]  = 33'h7;     irr_tab[3]  = 33'hB;     irr_tab[4]  = 33'h13;
    irr_tab[5]  = 33'h25;    irr_tab[6]  = 33'h43;    irr_tab[7]  = 33'h83;
    irr_tab[8]  = 33'h11D;   irr_tab[9]  = 33'h211;   irr_tab[10] = 33'h409;
    irr_tab[11] = 33'h805;   irr_tab[12] = 33'h1053;  irr_tab[13] = 33'h201B;
    irr_tab[14] = 33'h4443;  irr_tab[15] = 33'h8003;  irr_tab[16] = 33'h1100B;

    bus.sum_funct = 1; bus.exp_funct = 0; bus.red_funct = 0; bus.carry_option = 1;
    bus.polyn_grade = 4; bus.polyn_red_in = 19; bus.reduc_in = 64'hFFFF;
    bus.a = 32'hFFFFFFFF; bus.b = 1;
    #22;
    check("reset_hold", 160'(all_out()), 160'(0));
    rst_n = 1'b1;                         // released at t=22, between edges
    #1;
    check("reset_release", 160'(all_out()), 160'(0));

    drive(1, 0, 0, 1, 0, 0, 0, 32'hFFFFFFFF, 1);
    check("add_c.out", 160'(bus.out), 160'(0));
    check("add_c.carry", 160'(bus.sum_carry_out), 160'(1));
    drive(1, 0, 0, 0, 0, 0, 0, 32'hFFFFFFFF, 1);
    check("add_x.out", 160'(bus.out), 160'(32'hFFFFFFFE));
    check("add_x.carry", 160'(bus.sum_carry_out), 160'(0));

    drive(0, 0, 0, 1, 0, 0, 0, 3, 3);
    check("mul_int", 160'(bus.mult_out), 160'(9));
    drive(0, 0, 0, 0, 0, 0, 0, 3, 3);
    check("mul_cl", 160'(bus.mult_out), 160'(5));
    drive(0, 0, 0, 1, 0, 0, 0, 32'h10000, 32'h10000);
    check("mul_big", 160'(bus.mult_out), 160'(64'h1_0000_0000));

    drive(0, 1, 0, 1, 0, 0, 0, 32'hFFFFFFFF, 32'h1234);
    check("sq_int", 160'(bus.mult_out), 160'(64'hFFFFFFFE00000001));
    drive(0, 1, 0, 0, 0, 0, 0, 32'hFFFFFFFF, 32'h1234);
    check("sq_cl", 160'(bus.mult_out), 160'(64'h5555555555555555));

    drive(0, 0, 1, 0, 4, 19, m_clmul(6, 7), 0, 0);
    check("red_m4", 160'(bus.out_poly), 160'(1));
    drive(0, 0, 1, 1, 8, 285, 64'h8000, 0, 0);
    check("red_m8", 160'(bus.out_poly), 160'(32'h26));
    drive(0, 0, 1, 0, 1, 33'h3, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0);
    check("red_m1", 160'(bus.out_poly), 160'(0));
    drive(0, 0, 1, 0, 33, 33'h1_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0);
    check("red_m33", 160'(bus.out_poly), 160'(0));
    drive(1, 1, 1, 1, 4, 19, 18, 32'hFFFFFFFF, 1);
    check_model("prio_all");

    // Asynchronous reset mid-run, asserted and released between clock edges.
    drive(1, 0, 0, 1, 0, 0, 0, 32'hFFFFFFFF, 32'hFFFFFFFF);
    check("pre_reset.out", 160'(bus.out), 160'(32'hFFFFFFFE));
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset", 160'(all_out()), 160'(0));
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("post_release", 160'(all_out()), 160'(0));
    @(posedge clk);
    #1;
    check_model("first_after_reset");

    for (int n = 0; n < 1000; n++) begin
      m = $urandom_range(2, 16);
      p = irr_tab[m];
      if ($urandom_range(0, 3) == 0) p = p | (33'($urandom) << (m + 1));
      if ($urandom_range(0, 7) == 0) p[m] = 1'b0;
      if ($urandom_range(0, 9) == 0) m = $urandom_range(0, 63);
      v = {$urandom, $urandom};
      drive($urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0,
            1'($urandom), 6'(m), p, v, $urandom, $urandom);
      check_model("rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
